// File: rtl/rtc_pkg.sv
// Shared types and constants for the real-time clock core.
package rtc_pkg;

    // One BCD digit, 0-9.
    typedef logic [3:0] bcd_t;

    // Set-mode states, also exported on set_state for display blinking.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } set_state_e;

    // Field limits as BCD tens/units pairs.
    localparam bcd_t SEC_MAX_H  = 4'd5;
    localparam bcd_t SEC_MAX_L  = 4'd9;
    localparam bcd_t MIN_MAX_H  = 4'd5;
    localparam bcd_t MIN_MAX_L  = 4'd9;
    localparam bcd_t HOUR_MAX_H = 4'd2;
    localparam bcd_t HOUR_MAX_L = 4'd3;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX_H:MAX_L.
// carry is combinational: high when an increment is applied at the limit.
module bcd2_counter
    import rtc_pkg::*;
#(
    parameter bcd_t MAX_H = 4'd5,
    parameter bcd_t MAX_L = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] dig_h,
    output logic [3:0] dig_l,
    output logic       carry
);

    bcd_t dig_h_q, dig_h_d;
    bcd_t dig_l_q, dig_l_d;
    logic at_max;

    // The field limit is checked before the units digit rolls, so e.g. 23 -> 00 for hours.
    assign at_max = (dig_h_q == MAX_H) && (dig_l_q == MAX_L);
    assign carry  = inc && at_max;

    // Next-digit logic: clear wins over increment.
    always_comb begin
        dig_h_d = dig_h_q;
        dig_l_d = dig_l_q;
        if (clr) begin
            dig_h_d = 4'd0;
            dig_l_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                dig_h_d = 4'd0;
                dig_l_d = 4'd0;
            end else if (dig_l_q == 4'd9) begin
                dig_h_d = dig_h_q + 4'd1;
                dig_l_d = 4'd0;
            end else begin
                dig_l_d = dig_l_q + 4'd1;
            end
        end
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_h_q <= 4'd0;
            dig_l_q <= 4'd0;
        end else begin
            dig_h_q <= dig_h_d;
            dig_l_q <= dig_l_d;
        end
    end

    assign dig_h = dig_h_q;
    assign dig_l = dig_l_q;

endmodule

// File: rtl/rtc_time_counter.sv
// Real-time clock core: 1 s prescaler, HH:MM:SS BCD counters and a
// three-state set mode driven by single-cycle key pulses.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int TIME_1S = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [3:0] hour_l,
    output logic [3:0] hour_h,
    output logic [1:0] set_state,
    output logic       tick_1s
);

    localparam int CW = (TIME_1S > 1) ? $clog2(TIME_1S) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIME_1S - 1);

    set_state_e    state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic          tick_q, tick_d;

    logic run_stay;
    logic inc_ev;
    logic sec_inc, sec_clr, sec_carry;
    logic min_inc, min_carry;
    logic hour_inc, hour_carry_unused;

    // Staying in RUN this edge; a key_mode pulse always leaves RUN and drops any tick.
    assign run_stay = (state_q == ST_RUN) && !key_mode;
    // key_mode takes precedence over a coincident key_inc.
    assign inc_ev   = key_inc && !key_mode;

    // Prescaler counts only while running; it is forced to 0 in set modes and on the RUN-entry edge.
    assign cnt_d  = !run_stay ? '0 : ((cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1);
    // End-of-count is registered once, then becomes the tick on the following edge.
    assign wrap_d = run_stay && (cnt_q == CNT_MAX);
    assign tick_d = run_stay && wrap_q;

    // Increment routing: the tick drives the seconds chain; keys drive one field with no carry.
    assign sec_inc  = tick_d;
    assign sec_clr  = (state_q == ST_SET_MIN) && key_mode;
    assign min_inc  = (tick_d && sec_carry) || ((state_q == ST_SET_MIN) && inc_ev);
    assign hour_inc = (run_stay && min_carry) || ((state_q == ST_SET_HOUR) && inc_ev);

    // Set-mode FSM: RUN -> SET_HOUR -> SET_MIN -> RUN on each key_mode pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else if (key_mode) begin
            case (state_q)
                ST_RUN:      state_q <= ST_SET_HOUR;
                ST_SET_HOUR: state_q <= ST_SET_MIN;
                ST_SET_MIN:  state_q <= ST_RUN;
                default:     state_q <= ST_RUN;
            endcase
        end
    end

    // Prescaler, end-of-count flag and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            tick_q <= tick_d;
        end
    end

    bcd2_counter #(
        .MAX_H (SEC_MAX_H),
        .MAX_L (SEC_MAX_L)
    ) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .dig_h (sec_h),
        .dig_l (sec_l),
        .carry (sec_carry)
    );

    bcd2_counter #(
        .MAX_H (MIN_MAX_H),
        .MAX_L (MIN_MAX_L)
    ) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (1'b0),
        .dig_h (min_h),
        .dig_l (min_l),
        .carry (min_carry)
    );

    bcd2_counter #(
        .MAX_H (HOUR_MAX_H),
        .MAX_L (HOUR_MAX_L)
    ) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (hour_inc),
        .clr   (1'b0),
        .dig_h (hour_h),
        .dig_l (hour_l),
        .carry (hour_carry_unused)
    );

    assign set_state = state_q;
    assign tick_1s   = tick_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter with a short 1 s period.
module tb_rtc_time_counter;

    localparam int TIME_1S = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc  = 1'b0;
    logic [3:0] sec_l, sec_h, min_l, min_h, hour_l, hour_h;
    logic [1:0] set_state;
    logic       tick_1s;

    int n_checks  = 0;
    int n_errors  = 0;
    int set_ticks = 0;
    int cyc;

    wire [23:0] time_obs = {hour_h, hour_l, min_h, min_l, sec_h, sec_l};

    rtc_time_counter #(.TIME_1S(TIME_1S)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .sec_l     (sec_l),
        .sec_h     (sec_h),
        .min_l     (min_l),
        .min_h     (min_h),
        .hour_l    (hour_l),
        .hour_h    (hour_h),
        .set_state (set_state),
        .tick_1s   (tick_1s)
    );

    // Clock: rising edge is active; the bench drives and samples on the falling edge.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bcd_time(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // One-cycle key pulse; tick_1s is sampled on both falling edges.
    task automatic pulse(input logic m, input logic i);
        @(negedge clk);
        set_ticks += int'(tick_1s);
        key_mode = m;
        key_inc  = i;
        @(negedge clk);
        set_ticks += int'(tick_1s);
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b1);
    endtask

    // Count falling edges up to and including the next tick, bounded.
    task automatic wait_tick(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tick_1s && c < 50);
        if (!tick_1s) check("tick_timeout", {31'd0, tick_1s}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_time", time_obs, 24'h000000);
        check("rst_state", set_state, 2'b00);
        check("rst_tick", tick_1s, 1'b0);
        rst = 1'b0;

        // Free run: first tick 5 edges after release, then every 4 cycles
        wait_tick(cyc);
        check("first_tick_latency", cyc, 5);
        check("run_time_1", time_obs, bcd_time(0, 0, 1));
        for (int k = 2; k <= 67; k++) begin
            wait_tick(cyc);
            check("tick_spacing", cyc, 4);
            check("run_time", time_obs, bcd_time(0, k / 60, k % 60));
        end

        // Set hours from 00 with 25 pulses; seconds hold at 07
        set_ticks = 0;
        pulse(1'b1, 1'b0);
        check("enter_set_hour", set_state, 2'b01);
        check("set_hour_hold", time_obs, 24'h000107);
        inc_n(25);
        check("set_hour_25", time_obs, 24'h010107);

        // Set minutes 01 -> 58 -> wrap to 01, hours untouched
        pulse(1'b1, 1'b0);
        check("enter_set_min", set_state, 2'b10);
        inc_n(57);
        check("set_min_58", time_obs, 24'h015807);
        inc_n(3);
        check("set_min_wrap", time_obs, 24'h010107);
        check("no_tick_in_set", set_ticks, 0);

        // Back to RUN: seconds clear, first tick 5 edges later
        pulse(1'b1, 1'b0);
        check("back_to_run", set_state, 2'b00);
        check("sec_clear", time_obs, 24'h010100);
        wait_tick(cyc);
        check("rerun_latency", cyc, 5);
        check("rerun_time", time_obs, 24'h010101);

        // Simultaneous key_mode + key_inc at hour 05
        pulse(1'b1, 1'b0);
        inc_n(4);
        check("hour_05", time_obs, 24'h050101);
        pulse(1'b1, 1'b1);
        check("both_state", set_state, 2'b10);
        check("both_hour", time_obs, 24'h050101);
        pulse(1'b1, 1'b0);
        check("run_again", time_obs, 24'h050100);
        pulse(1'b0, 1'b1);
        check("inc_in_run_state", set_state, 2'b00);
        check("inc_in_run_time", time_obs, 24'h050100);

        // Preload 23:59 and run to midnight
        pulse(1'b1, 1'b0);
        inc_n(18);
        pulse(1'b1, 1'b0);
        inc_n(58);
        check("preload_state", set_state, 2'b10);
        check("preload_time", time_obs, 24'h235900);
        pulse(1'b1, 1'b0);
        check("preload_run", time_obs, 24'h235900);
        wait_tick(cyc);
        check("preload_latency", cyc, 5);
        check("late_time_1", time_obs, bcd_time(23, 59, 1));
        for (int s = 2; s <= 59; s++) begin
            wait_tick(cyc);
            check("late_spacing", cyc, 4);
            check("late_time", time_obs, bcd_time(23, 59, s));
        end
        repeat (3) @(negedge clk);
        check("pre_midnight_tick", tick_1s, 1'b0);
        check("pre_midnight_time", time_obs, 24'h235959);
        @(negedge clk);
        check("midnight_tick", tick_1s, 1'b1);
        check("midnight_wrap", time_obs, 24'h000000);

        // Reset in SET_MIN at 12:34 acts only on the clock edge
        pulse(1'b1, 1'b0);
        inc_n(12);
        pulse(1'b1, 1'b0);
        inc_n(34);
        check("pre_rst_state", set_state, 2'b10);
        check("pre_rst_time", time_obs, 24'h123400);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_waits_edge", time_obs, 24'h123400);
        @(negedge clk);
        check("mid_rst_time", time_obs, 24'h000000);
        check("mid_rst_state", set_state, 2'b00);
        check("mid_rst_tick", tick_1s, 1'b0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
